// File: rtl/logic_result_stage.sv
// Registered output stage for the bitwise logic unit. It holds a two-entry skid buffer,
// stores status flags captured with each word, and counts delivered results.
module logic_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_zero,
  output logic                       out_neg,
  output logic                       out_parity,
  output logic [$clog2(WIDTH+1)-1:0] out_popcnt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CNT_W-1:0]           out_count
);
  localparam int PCW = $clog2(WIDTH+1);
  // Entry layout: {popcnt, parity, neg, zero, data}
  localparam int EW  = WIDTH + 3 + PCW;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state_reg, state_next;
  logic [EW-1:0]    main_reg, main_next;
  logic [EW-1:0]    skid_reg, skid_next;
  logic [EW-1:0]    in_entry;
  logic [PCW-1:0]   in_popcnt;
  logic [CNT_W-1:0] count_reg;
  logic             accept, deliver;

  always_comb begin
    in_popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      in_popcnt = in_popcnt + PCW'(in_data[i]);
    end
  end

  assign in_entry = {in_popcnt, ^in_data, in_data[WIDTH-1], (in_data == '0), in_data};

  // Both handshake sides decode only registered occupancy, so out_ready never reaches in_ready
  assign in_ready  = (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          main_next  = in_entry;
          state_next = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          main_next = in_entry;
        end else if (accept) begin
          skid_next  = in_entry;
          state_next = FULL;
        end else if (deliver) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          main_next  = skid_reg;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
      if (deliver) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  assign out_data   = main_reg[WIDTH-1:0];
  assign out_zero   = main_reg[WIDTH];
  assign out_neg    = main_reg[WIDTH+1];
  assign out_parity = main_reg[WIDTH+2];
  assign out_popcnt = main_reg[EW-1:WIDTH+3];
  assign out_count  = count_reg;

endmodule

// File: tb/tb_logic_result_stage.sv
// Bench for logic_result_stage: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and a 4-bit counter instance for wrap.
module tb_logic_result_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_zero, out_neg, out_parity, out_valid;
  logic [31:0] out_data;
  logic [5:0]  out_popcnt;
  logic [15:0] out_count;

  logic        d4_in_ready, d4_zero, d4_neg, d4_parity, d4_valid;
  logic [31:0] d4_data;
  logic [5:0]  d4_popcnt;
  logic [3:0]  d4_count;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] q[$];
  int unsigned cnt = 0;

  always #5 clk = ~clk;

  logic_result_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_zero(out_zero), .out_neg(out_neg), .out_parity(out_parity),
    .out_popcnt(out_popcnt), .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count)
  );

  logic_result_stage #(.WIDTH(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(d4_in_ready),
    .out_data(d4_data), .out_zero(d4_zero), .out_neg(d4_neg), .out_parity(d4_parity),
    .out_popcnt(d4_popcnt), .out_valid(d4_valid), .out_ready(out_ready), .out_count(d4_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two words; accepts whenever it has room
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        cnt = 0;
      end else begin
        automatic bit acc = in_valid && (q.size() < 2);
        automatic bit del = (q.size() > 0) && out_ready;
        if (del) begin
          void'(q.pop_front());
          cnt++;
        end
        if (acc) q.push_back(in_data);
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("out_count", 64'(out_count), 64'(cnt & 32'hFFFF));
      chk("d4_count", 64'(d4_count), 64'(cnt & 32'hF));
      if (q.size() > 0) begin
        chk("out_data", 64'(out_data), 64'(q[0]));
        chk("out_zero", 64'(out_zero), 64'(q[0] == 32'h0));
        chk("out_neg", 64'(out_neg), 64'(q[0][31]));
        chk("out_parity", 64'(out_parity), 64'($countones(q[0]) % 2));
        chk("out_popcnt", 64'(out_popcnt), 64'($countones(q[0])));
        chk("d4_data", 64'(d4_data), 64'(q[0]));
      end
    end
  end

  initial begin
    // 1: async reset while full, then idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 32'hA5A5_0001;
    @(negedge clk);
    in_data = 32'h8000_0003;
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_full_in_ready", 64'(in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("t1_rst_valid", 64'(out_valid), 64'd0);
    chk("t1_rst_data", 64'(out_data), 64'd0);
    chk("t1_rst_flags", 64'({out_zero, out_neg, out_parity}), 64'd0);
    chk("t1_rst_popcnt", 64'(out_popcnt), 64'd0);
    chk("t1_rst_in_ready", 64'(in_ready), 64'd1);
    chk("t1_rst_count", 64'(out_count), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_idle_valid", 64'(out_valid), 64'd0);
    end

    // 2: all-ones then all-zeros with consumer ready
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("t2_popcnt32", 64'(out_popcnt), 64'd32);
    chk("t2_neg1", 64'(out_neg), 64'd1);
    chk("t2_parity0", 64'(out_parity), 64'd0);
    chk("t2_zero0", 64'(out_zero), 64'd0);
    in_data = 32'h0;
    @(negedge clk);
    chk("t2_zero1", 64'(out_zero), 64'd1);
    chk("t2_popcnt0", 64'(out_popcnt), 64'd0);
    chk("t2_neg0", 64'(out_neg), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t2_count2", 64'(out_count), 64'd2);

    // 3: back-pressure fills skid; FIFO order on release
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h1;
    @(negedge clk);
    in_data = 32'h3;
    @(negedge clk);
    chk("t3_in_ready0", 64'(in_ready), 64'd0);
    in_data = 32'h7;
    @(negedge clk);
    chk("t3_hold_in_ready0", 64'(in_ready), 64'd0);
    chk("t3_out1", 64'(out_data), 64'h1);
    chk("t3_par1", 64'(out_parity), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_out3", 64'(out_data), 64'h3);
    chk("t3_par3", 64'(out_parity), 64'd0);
    @(negedge clk);
    chk("t3_out7", 64'(out_data), 64'h7);
    chk("t3_par7", 64'(out_parity), 64'd1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_drained", 64'(out_valid), 64'd0);

    // 4: full throughput streaming
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 32'h100 + 32'(i);
      @(negedge clk);
      chk("t4_in_ready", 64'(in_ready), 64'd1);
      chk("t4_valid", 64'(out_valid), 64'd1);
      chk("t4_data", 64'(out_data), 64'(32'h100 + 32'(i)));
    end
    in_valid = 1'b0;
    @(negedge clk);

    // 6: 4-bit counter wrap
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 19; i++) begin
      in_data = 32'(i) * 32'h0101_0101;
      if (i == 17) in_valid = 1'b0;
      @(negedge clk);
      if (i == 15) chk("t6_cnt15", 64'(d4_count), 64'd15);
      if (i == 16) chk("t6_cnt0", 64'(d4_count), 64'd0);
      if (i == 17) chk("t6_cnt1", 64'(d4_count), 64'd1);
    end

    // 5: random valid/ready; upstream holds a word until it is taken
    for (int i = 0; i < 10000; i++) begin
      if (!in_valid || in_ready) begin
        in_valid = ($urandom_range(0, 2) != 0);
        case ($urandom_range(0, 5))
          0: in_data = 32'h0;
          1: in_data = 32'hFFFF_FFFF;
          2: in_data = 32'h8000_0000;
          default: in_data = $urandom();
        endcase
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_drained", 64'(out_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
